// File: rtl/order_ingress_queue_if.sv
// Handshake bundle between the upstream parser, order_ingress_queue and the matching engine.
// slave = the queue's view; master = the surrounding environment (parser + engine).
interface order_ingress_queue_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              ord_valid;
  logic [DATA_W-1:0] ord_data;
  logic              engine_busy;

  modport slave (
    input  s_valid, s_data, engine_busy,
    output s_ready, ord_valid, ord_data
  );

  modport master (
    output s_valid, s_data, engine_busy,
    input  s_ready, ord_valid, ord_data
  );
endinterface

// File: rtl/order_ingress_queue.sv
// Screens, buffers and issues order words one at a time to order_book_top.
// Optional price-band screening is enabled by defining INGRESS_PRICE_BAND_EN.
module order_ingress_queue #(
  parameter int          DEPTH       = 16,
  parameter int          ACK_TIMEOUT = 8,
  parameter logic [15:0] PRICE_LO    = 16'd1,
  parameter logic [15:0] PRICE_HI    = 16'hFFFE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  order_ingress_queue_if.slave   bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            drop_count,
  output logic                   reject_pulse,
  output logic                   timeout_pulse
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty;
  logic              hs, qty_ok, price_ok, push, reject, pop, to_hit;
  state_t            state, next_state;
  logic [TMR_W-1:0]  timer;
  logic              ord_vld_p1;
  logic [DATA_W-1:0] ord_data_p1;

  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty       = (wr_ptr == rd_ptr);
  assign bus.s_ready = !full;

  // Ingress screening: malformed words are consumed but never stored
  assign hs     = bus.s_valid && !full;
  assign qty_ok = (bus.s_data[13:0] != 14'd0);

`ifdef INGRESS_PRICE_BAND_EN
  logic [15:0] price;
  assign price    = bus.s_data[31:16];
  assign price_ok = (price >= PRICE_LO) && (price <= PRICE_HI);
`else
  // Band limits fold to a constant; no comparator is built.
  localparam logic BAND_OFF = (PRICE_LO <= PRICE_HI) || 1'b1;
  assign price_ok = BAND_OFF;
`endif

  assign push   = hs && qty_ok && price_ok;
  assign reject = hs && !(qty_ok && price_ok);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      drop_count   <= '0;
      reject_pulse <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + PTR_ONE;
        2'b01:   fifo_count <= fifo_count - PTR_ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (reject) drop_count <= sat_inc(drop_count);
      reject_pulse <= reject;
    end
  end

  // Issue FSM: one order in flight, tracked through the engine's busy/idle cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= next_state;
      timer <= (state == WAIT_ACK) ? timer + TMR_ONE : '0;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    to_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.engine_busy) begin
          next_state = ISSUE;
          pop        = 1'b1;
        end
      end
      ISSUE:     next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.engine_busy) begin
          next_state = WAIT_DONE;
        end else if (timer == TMR_LAST) begin
          next_state = IDLE;
          to_hit     = 1'b1;
        end
      end
      WAIT_DONE: if (!bus.engine_busy) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output stage: the pop edge loads the issue register, so ord_valid spans the ISSUE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord_vld_p1    <= 1'b0;
      ord_data_p1   <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      ord_vld_p1    <= pop;
      timeout_pulse <= to_hit;
      if (pop) ord_data_p1 <= mem[rd_ptr[AW-1:0]];
    end
  end

  assign bus.ord_valid = ord_vld_p1;
  assign bus.ord_data  = ord_data_p1;

endmodule

// File: tb/tb_order_ingress_queue.sv
// Directed bench for order_ingress_queue: vector table for single orders plus
// hand-written fill/wrap, acknowledge-timeout and mid-transaction reset sequences.
module tb_order_ingress_queue;

  localparam int DEPTH = 16;
`ifdef INGRESS_PRICE_BAND_EN
  localparam logic [15:0] P_LO = 16'd90;
  localparam logic [15:0] P_HI = 16'd110;
  localparam int NV = 3;
`else
  localparam logic [15:0] P_LO = 16'd1;
  localparam logic [15:0] P_HI = 16'hFFFE;
  localparam int NV = 5;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  order_ingress_queue_if bus ();
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]            drop_count;
  logic                   reject_pulse;
  logic                   timeout_pulse;

  order_ingress_queue #(
    .DEPTH(DEPTH), .ACK_TIMEOUT(8), .PRICE_LO(P_LO), .PRICE_HI(P_HI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fifo_count(fifo_count), .drop_count(drop_count),
    .reject_pulse(reject_pulse), .timeout_pulse(timeout_pulse)
  );

  typedef struct {
    logic [15:0] price;
    logic        side;
    logic        id;
    logic [13:0] qty;
    logic        exp_issue;
    logic [15:0] exp_drops;
  } vec_t;

  vec_t vecs [NV];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] mk(input logic [15:0] p, input logic s, input logic i,
                                     input logic [13:0] q);
    return {p, s, i, q};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic engine_ack;
    bus.engine_busy = 1'b1;
    tick;
    tick;
    bus.engine_busy = 1'b0;
    tick;
    tick;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_ready"},       bus.s_ready,   1);
    chk({tag, "_ord_valid"},     bus.ord_valid, 0);
    chk({tag, "_ord_data"},      bus.ord_data,  0);
    chk({tag, "_fifo_count"},    fifo_count,    0);
    chk({tag, "_drop_count"},    drop_count,    0);
    chk({tag, "_reject_pulse"},  reject_pulse,  0);
    chk({tag, "_timeout_pulse"}, timeout_pulse, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w, wb;
    logic        found, seen;
    int          to_at, b_at;

`ifdef INGRESS_PRICE_BAND_EN
    vecs[0] = '{16'd89,  1'b1, 1'b0, 14'd10, 1'b0, 16'd1};
    vecs[1] = '{16'd110, 1'b0, 1'b1, 14'd10, 1'b1, 16'd1};
    vecs[2] = '{16'd111, 1'b1, 1'b1, 14'd10, 1'b0, 16'd2};
`else
    vecs[0] = '{16'd105,   1'b0, 1'b1, 14'd50,     1'b1, 16'd0};
    vecs[1] = '{16'd100,   1'b1, 1'b0, 14'd0,      1'b0, 16'd1};
    vecs[2] = '{16'hFFFF,  1'b1, 1'b0, 14'h3FFF,   1'b1, 16'd1};
    vecs[3] = '{16'd0,     1'b0, 1'b0, 14'd1,      1'b1, 16'd1};
    vecs[4] = '{16'd200,   1'b1, 1'b1, 14'd0,      1'b0, 16'd2};
`endif

    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.engine_busy = 1'b0;
    tick;
    tick;
    check_reset_values("reset");
    rst_n = 1'b1;
    tick;

    for (int v = 0; v < NV; v++) begin
      w = mk(vecs[v].price, vecs[v].side, vecs[v].id, vecs[v].qty);
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      tick;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      chk("vec_reject_pulse", reject_pulse, !vecs[v].exp_issue);
      chk("vec_count_after_push", fifo_count, vecs[v].exp_issue ? 1 : 0);
      chk("vec_ord_valid_early", bus.ord_valid, 0);
      tick;
      chk("vec_ord_valid", bus.ord_valid, vecs[v].exp_issue);
      if (vecs[v].exp_issue) chk("vec_ord_data", bus.ord_data, w);
      chk("vec_reject_one_cycle", reject_pulse, 0);
      chk("vec_count_after_issue", fifo_count, 0);
      if (vecs[v].exp_issue) begin
        bus.engine_busy = 1'b1;
        tick;
        chk("vec_single_pulse", bus.ord_valid, 0);
        tick;
        bus.engine_busy = 1'b0;
        tick;
      end else begin
        tick;
      end
      chk("vec_drop_count", drop_count, vecs[v].exp_drops);
      tick;
    end

    // Fill past capacity with the engine busy
    bus.engine_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("fill_s_ready", bus.s_ready, (i < DEPTH) ? 1 : 0);
      bus.s_valid = 1'b1;
      bus.s_data  = mk(16'(1000 + i), i[0], i[1], 14'(i + 1));
      tick;
    end
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    chk("fill_s_ready_final", bus.s_ready, 0);
    chk("fill_count", fifo_count, DEPTH);
    chk("fill_no_issue", bus.ord_valid, 0);

    bus.engine_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      found = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (bus.ord_valid) begin
          found = 1'b1;
          break;
        end
        tick;
      end
      chk("drain_found", found, 1);
      chk("drain_order", bus.ord_data, mk(16'(1000 + k), k[0], k[1], 14'(k + 1)));
      bus.engine_busy = 1'b1;
      tick;
      chk("drain_single_pulse", bus.ord_valid, 0);
      tick;
      bus.engine_busy = 1'b0;
      tick;
    end
    tick;
    chk("drain_count", fifo_count, 0);
    chk("drain_s_ready", bus.s_ready, 1);

    // Engine never acknowledges the first of two orders
    w  = mk(16'd500, 1'b1, 1'b0, 14'd3);
    wb = mk(16'd501, 1'b0, 1'b1, 14'd4);
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    tick;
    bus.s_data  = wb;
    tick;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    chk("to_first_issue", bus.ord_valid, 1);
    chk("to_first_data", bus.ord_data, w);
    chk("to_push_pop_count", fifo_count, 1);
    to_at = 0;
    b_at  = 0;
    for (int c = 1; c <= 14; c++) begin
      tick;
      if (timeout_pulse && to_at == 0) to_at = c;
      if (bus.ord_valid && b_at == 0) begin
        b_at = c;
        break;
      end
    end
    chk("to_pulse_cycle", to_at, 9);
    chk("to_next_issue_cycle", b_at, 10);
    chk("to_next_data", bus.ord_data, wb);
    chk("to_pulse_one_cycle", timeout_pulse, 0);
    engine_ack;

    // Reset while WAIT_DONE with five orders still queued
    for (int i = 0; i < 6; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = mk(16'(300 + i), 1'b1, 1'b0, 14'd7);
      tick;
      if (bus.ord_valid) bus.engine_busy = 1'b1;
    end
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    tick;
    chk("rst_queued", fifo_count, 5);
    chk("rst_drops_before", drop_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    tick;
    rst_n = 1'b1;
    tick;
    bus.engine_busy = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.ord_valid) seen = 1'b1;
      tick;
    end
    chk("rst_no_issue", seen, 0);
    chk("rst_count_stays", fifo_count, 0);

    w = mk(16'd77, 1'b0, 1'b0, 14'd9);
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    tick;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    tick;
    chk("post_rst_issue", bus.ord_valid, 1);
    chk("post_rst_data", bus.ord_data, w);
    engine_ack;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/order_ingress_queue.md
# order_ingress_queue

Buffers incoming 32-bit order words from the upstream parser and feeds them one at a time into `order_book_top`, which is directly downstream. Each order is presented as a single-cycle `input_valid` pulse, and the block waits for the engine's busy/idle cycle before issuing the next one. Malformed orders are screened and dropped at ingress, and every drop is counted.

## Interface
- `DEPTH`, 16 — FIFO entries; power of 2, minimum 4.
- `ACK_TIMEOUT`, 8 — cycles to wait for `engine_busy` to rise after an issue.
- `PRICE_LO`, 1 — lowest accepted price (used only with `INGRESS_PRICE_BAND_EN`).
- `PRICE_HI`, 16'hFFFE — highest accepted price (used only with `INGRESS_PRICE_BAND_EN`).

Ports:
- `clk` in 1 — single clock for the whole block.
- `rst_n` in 1 — asynchronous, active-low reset.
- `s_valid` in 1 — upstream order word valid.
- `s_ready` out 1 — block can accept a word; equals `!full`.
- `s_data` in 32 — order word: Price[31:16], Side[15] (1 = buy), ID[14] (1 = bot), Qty[13:0].
- `ord_valid` out 1 — one-cycle issue pulse; connects to engine `input_valid`.
- `ord_data` out 32 — issued order; connects to engine `input_data`.
- `engine_busy` in 1 — engine busy flag.
- `fifo_count` out $clog2(DEPTH)+1 — current FIFO occupancy.
- `drop_count` out 16 — number of rejected orders; saturates at 16'hFFFF.
- `reject_pulse` out 1 — one cycle per rejected order.
- `timeout_pulse` out 1 — one cycle per acknowledge timeout.

## Operation
- Accept rule: an order is accepted when `s_valid && s_ready`.
- Rejection:
  - A word with Qty == 0 is rejected: not written to the FIFO, `drop_count` increments, `reject_pulse` asserts.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than the address, so wrap-around is implicit.
  - `full` is true when the pointer addresses are equal and the MSBs differ.
  - `s_ready` depends only on `full`. A pop in the same cycle does not open space for a push when full.
- Issue FSM states: `IDLE`, `ISSUE`, `WAIT_ACK`, `WAIT_DONE`.
  - `IDLE` → `ISSUE` when the FIFO is non-empty and `engine_busy == 0`.
  - `ISSUE` (1 cycle):
    - `ord_valid = 1` and `ord_data` = FIFO head; the head is popped this cycle.
    - Then go to `WAIT_ACK` and clear the timer.
  - `WAIT_ACK`:
    - `engine_busy == 1` → `WAIT_DONE`.
    - The timer reaches `ACK_TIMEOUT` → pulse `timeout_pulse`, return to `IDLE`. The issued order is not replayed.
  - `WAIT_DONE`: `engine_busy == 0` → `IDLE`.
- Simultaneous events:
  - A push and a pop in the same cycle leave `fifo_count` unchanged.
  - A reject and an issue in the same cycle are independent.
- `drop_count` stops at 16'hFFFF and never wraps.
- Reset mid-operation:
  - All pointers, counters and the FSM clear immediately; buffered orders are lost.
  - An engine transaction already in flight is not tracked after reset.

## Timing
- Reset values:
  - `s_ready = 1`
  - `ord_valid = 0`
  - `ord_data = 0`
  - `fifo_count = 0`
  - `drop_count = 0`
  - `reject_pulse = 0`
  - `timeout_pulse = 0`
  - FSM = `IDLE`
- All outputs are registered except `s_ready`, which is decoded from the pointers.
- Latency from a push into an empty FIFO with the engine idle to `ord_valid`: 2 cycles (write at edge N, `IDLE` sees non-empty at N+1, `ord_valid` high from N+1 to N+2).
- Minimum issue spacing is 4 cycles (`ISSUE`, `WAIT_ACK`, `WAIT_DONE`, `IDLE`). The actual spacing is set by the engine.
- `ord_valid` is never high for two consecutive cycles.
- `ord_data` holds its value after the pulse until the next issue.
- `reject_pulse` asserts on the cycle after the rejected handshake.

## Configuration
- Macro: `INGRESS_PRICE_BAND_EN`.
  - Defined: an order is also rejected when Price < `PRICE_LO` or Price > `PRICE_HI`. Rejected orders are counted in `drop_count` and pulse `reject_pulse`, same as Qty == 0.
  - Undefined: only Qty == 0 is screened. The band comparators are not synthesized, and `PRICE_LO`/`PRICE_HI` are ignored.

## Test plan
- Hold the engine model idle, then push sell 105×50. Required: `ord_valid` pulses once 2 cycles after the push, with `ord_data` = {16'd105, 1'b0, 1'b1, 14'd50}. `fifo_count` returns to 0.
- Push 20 orders back-to-back with the engine busy. Required:
  - `s_ready` drops after 16 words and `fifo_count` = 16.
  - After the engine frees, all 16 words issue in push order, with FIFO wrap verified.
- Push Qty = 0 at price 100. Required: no issue, `drop_count` = 1, `reject_pulse` high for one cycle.
- Engine model never raises busy after the issue. Required: `timeout_pulse` fires 8 cycles after `ISSUE`, then the next queued order issues.
- With `INGRESS_PRICE_BAND_EN`, `PRICE_LO = 90`, `PRICE_HI = 110`: push price 89 → rejected; push price 110 → issued; push price 111 → rejected. Final `drop_count` = 2.
- Assert `rst_n` low while in `WAIT_DONE` with 5 orders queued. Required: every output returns to its reset value immediately and no `ord_valid` appears until new pushes arrive.
